// File: rtl/mux4_scan_sampler.sv
// Scans a 4:1 mux through channels 0..3, samples each after a settle delay and
// hands the assembled 4-bit word downstream on valid/ready. Optional io_parity
// output is enabled by defining MUX4_SCAN_PARITY_EN.
module mux4_scan_sampler #(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       io_start,
  input  logic       io_continuous,
  input  logic       io_mux_out,
  output logic [1:0] io_selector,
  output logic       io_busy,
  output logic [3:0] io_data,
  output logic       io_valid,
  input  logic       io_ready
`ifdef MUX4_SCAN_PARITY_EN
  ,
  output logic       io_parity
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state, state_d;
  logic [1:0]       ch, ch_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [3:0]       shadow, shadow_d;
  logic [3:0]       data, data_d;
  logic             valid, valid_d;
  logic             parity;

  localparam logic [CNT_W-1:0] SETTLE = CNT_W'(SETTLE_CYCLES);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      ch     <= 2'd0;
      cnt    <= '0;
      shadow <= 4'd0;
      data   <= 4'd0;
      valid  <= 1'b0;
      parity <= 1'b0;
    end else begin
      state  <= state_d;
      ch     <= ch_d;
      cnt    <= cnt_d;
      shadow <= shadow_d;
      data   <= data_d;
      valid  <= valid_d;
      // data_d equals data whenever the word is held, so parity tracks it
      parity <= ^data_d;
    end
  end

  always_comb begin
    state_d  = state;
    ch_d     = ch;
    cnt_d    = cnt;
    shadow_d = shadow;
    data_d   = data;
    valid_d  = valid;
    case (state)
      IDLE: begin
        if (io_start) begin
          state_d = SCAN;
          ch_d    = 2'd0;
          cnt_d   = '0;
        end
      end
      SCAN: begin
        if (cnt != SETTLE) begin
          cnt_d = cnt + CNT_W'(1);
        end else begin
          shadow_d[ch] = io_mux_out;
          cnt_d        = '0;
          ch_d         = ch + 2'd1;
          if (ch == 2'd3) begin
            // last channel bypasses shadow so the word is complete this edge
            data_d  = {io_mux_out, shadow[2:0]};
            valid_d = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (valid && io_ready) begin
          valid_d = 1'b0;
          if (io_continuous) begin
            state_d = SCAN;
            ch_d    = 2'd0;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign io_selector = ch;
  assign io_busy     = (state == SCAN);
  assign io_data     = data;
  assign io_valid    = valid;
`ifdef MUX4_SCAN_PARITY_EN
  assign io_parity   = parity;
`else
  logic unused_parity;
  assign unused_parity = parity;
`endif

endmodule

// File: doc/mux4_scan_sampler.md
Name: mux4_scan_sampler

Overview:
- Sequencer that wraps the 4:1 mux stage from both sides: drives the mux's 2-bit selector and consumes its 1-bit output.
- Steps the selector through channels 0..3 and waits a programmable settle time on each channel.
- Samples the mux output once per channel and assembles the four samples into a 4-bit word.
- Presents the word downstream on a valid/ready handshake.

Parameters:
- SETTLE_CYCLES, 1, extra cycles per channel between selector change and sample; 0 allowed; range 0..15.
- CNT_W, 4, width of the settle counter; must hold SETTLE_CYCLES.

Ports:
- clock  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- io_start  input  1  begin one scan; sampled only in IDLE.
- io_continuous  input  1  after a handshake, rescan immediately instead of returning to IDLE.
- io_mux_out  input  1  output of the 4:1 mux being scanned.
- io_selector  output  2  channel select driven to the mux.
- io_busy  output  1  high while in SCAN.
- io_data  output  4  assembled word; bit n = sample of channel n.
- io_valid  output  1  io_data is valid.
- io_ready  input  1  downstream accepts io_data.

Behaviour:
- State machine: IDLE, SCAN, DONE. Internal registers: ch (2b), cnt (CNT_W), shadow (4b).
- Reset asserted, at any time including mid-scan:
  - state = IDLE, ch = 0, cnt = 0, shadow = 0.
  - io_selector = 0, io_data = 0, io_valid = 0, io_busy = 0.
  - An in-progress scan is abandoned; no partial word is ever output.
- IDLE, io_start = 1 at an edge: state -> SCAN, ch = 0, cnt = 0. io_start while not IDLE is ignored (not queued).
- io_selector = ch combinationally from the register, so it changes right after the edge.
- SCAN, each edge:
  - If cnt != SETTLE_CYCLES: cnt++.
  - Else: shadow[ch] <= io_mux_out, cnt <= 0, ch <= ch+1 (wraps 3 -> 0).
- Each channel occupies exactly SETTLE_CYCLES+1 edges in SCAN.
- Sampling channel 3:
  - At the same edge, io_data <= shadow with bit 3 replaced by io_mux_out, io_valid <= 1, state -> DONE.
  - ch wraps to 0, so io_selector returns to 0.
- Latency: io_start captured at edge k -> io_valid high after edge k + 4*(SETTLE_CYCLES+1). Default: 8 edges.
- io_data changes only at that completion edge. It is otherwise held, including throughout a subsequent SCAN.
- DONE:
  - io_valid stays high and io_data stays stable until io_valid && io_ready at an edge.
  - At that edge io_valid <= 0. If io_continuous = 1 (sampled at that edge), state -> SCAN with ch = 0, cnt = 0; otherwise state -> IDLE.
  - io_ready low holds DONE indefinitely; no samples are taken.
- io_ready while io_valid = 0 has no effect.
- io_busy = (state == SCAN); low in IDLE and DONE.
- io_continuous is read only at the handshake edge; changing it mid-scan has no effect on the current scan.

Optional Feature:
- Macro MUX4_SCAN_PARITY_EN.
- Defined:
  - Extra output io_parity (1b) = XOR of the four bits of io_data.
  - Registered in the same edge as io_data, reset 0, held with io_data.
- Undefined: port io_parity absent; behaviour otherwise identical.

Test Plan:
- Reset/idle: drive reset = 0 mid-scan (after 3 edges of SCAN) -> io_valid = 0, io_busy = 0, io_selector = 0, io_data = 0 immediately. Release reset -> stays IDLE until io_start.
- Single scan, SETTLE_CYCLES = 1: model the mux with inputs {1,0,1,1} (ch0..ch3) and io_ready = 1. Pulse io_start at edge k -> io_selector sequence 0,0,1,1,2,2,3,3, then io_valid high after edge k+8 with io_data = 4'b1101. Returns to IDLE after one valid cycle; parity = 1 when MUX4_SCAN_PARITY_EN is defined.
- Backpressure: hold io_ready = 0 for 5 cycles after io_valid -> io_valid and io_data stable for 5 cycles, io_busy = 0. Raising io_ready -> io_valid drops after the next edge.
- Continuous: io_continuous = 1, io_ready = 1, mux input pattern changed to {0,1,1,0} between scans -> consecutive words 4'b1101 then 4'b0110, with 9 edges between valid assertions (8 scan + 1 DONE). Ignored io_start pulses during SCAN cause no extra scan.
- SETTLE_CYCLES = 0: channel inputs all 1 -> io_selector changes every edge, io_valid after 4 edges, io_data = 4'hF.
